// File: rtl/ft601q_burst_tx.sv
// ---------------------------------------------------------------------------
// ft601q_burst_tx
//
// Purpose:
//   Transmit-side bridge from a simple user write port onto the FT601Q/FT600
//   245-style synchronous FIFO bus.  User words (data plus byte enables) are
//   buffered in a show-ahead FIFO.  A small controller (IDLE -> ARM -> BURST)
//   sends them to the device in bursts of at most BURST words.  A burst is
//   launched when a full burst is buffered, when a flush has been requested,
//   or (optionally) when a partial burst has sat idle for too long.
//
// Parameters:
//   DATA_W   FT bus width in bits (16 or 32).
//   DEPTH    FIFO depth in words (power of two, at least 2*BURST).
//   BURST    Maximum words per bus burst (at least 1).
//   TIMEOUT  Idle cycles before a partial burst is auto-flushed (at least 2).
//
// Ports:
//   ft_clk     bus clock, the only clock (rising edge)
//   ft_rst     synchronous active-high reset
//   wr_en      user write strobe
//   wr_data    user write word
//   wr_be      user byte enables, stored alongside the word
//   wr_full    FIFO full; writes are dropped while high
//   wr_dcnt    FIFO occupancy in words
//   flush      pulse: send all buffered words without waiting for a full burst
//   busy       high while the controller is in ARM or BURST
//   FT_TXE_N   device can accept data (active low)
//   FT_WR_N    bus write strobe (active low)
//   FT_BE      bus byte enables (FIFO head)
//   FT_DATA    bus data (FIFO head), output only
//   FT_RD_N    tied high
//   FT_OE_N    tied high
//   FT_SIWU_N  tied high
//
// Build option:
//   FT601Q_TX_TIMEOUT_FLUSH_EN  when defined, a partial burst left idle for
//   TIMEOUT cycles is launched automatically.  When undefined there is no
//   timeout counter and partial bursts only leave through flush.
// ---------------------------------------------------------------------------
module ft601q_burst_tx #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int BURST   = 256,
  parameter int TIMEOUT = 4096
) (
  input  logic                     ft_clk,
  input  logic                     ft_rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_be,
  output logic                     wr_full,
  output logic [$clog2(DEPTH):0]   wr_dcnt,
  input  logic                     flush,
  output logic                     busy,
  input  logic                     FT_TXE_N,
  output logic                     FT_WR_N,
  output logic [DATA_W/8-1:0]      FT_BE,
  output logic [DATA_W-1:0]        FT_DATA,
  output logic                     FT_RD_N,
  output logic                     FT_OE_N,
  output logic                     FT_SIWU_N
);

  localparam int BE_W = DATA_W / 8;
  localparam int WW   = DATA_W + BE_W;
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int RW   = $clog2(BURST + 1);

  localparam logic [CW-1:0] BURST_C = CW'(BURST);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [RW-1:0] BURST_R = RW'(BURST);

  // BURST is a parameter name, so the state literals carry a prefix.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_BURST = 2'd2
  } state_e;

  // FIFO storage and pointers
  logic [WW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Controller state
  state_e        state_q, state_d;
  logic [RW-1:0] remain_q, remain_d;
  logic          pend_q, pend_d;
  logic          wr_n_q, wr_n_d;
  logic          busy_q, busy_d;

  // Handshake and launch decode
  logic          wr_accept;
  logic          xfer;
  logic          full_launch;
  logic          flush_launch;
  logic          timeout_fire;
  logic          launch;
  logic [RW-1:0] launch_len;
  logic [WW-1:0] head;

  assign wr_full   = (cnt_q == DEPTH_C);
  assign wr_accept = wr_en & ~wr_full;

  // FT_WR_N is only low in BURST, and BURST is only entered with a non-zero
  // remaining count, so the strobe plus TXE is the whole transfer condition.
  assign xfer = (state_q == ST_BURST) & ~wr_n_q & ~FT_TXE_N;

  assign full_launch  = (cnt_q >= BURST_C);
  assign flush_launch = pend_q & (cnt_q != '0);

  // Below a full burst the count is guaranteed to fit the remaining counter.
  assign launch_len = full_launch ? BURST_R : cnt_q[RW-1:0];

  assign launch = (state_q == ST_IDLE) & (full_launch | flush_launch | timeout_fire);

`ifdef FT601Q_TX_TIMEOUT_FLUSH_EN
  localparam int TW = $clog2(TIMEOUT);

  logic [TW-1:0] to_q, to_d;
  logic          to_window;

  // Only a partial burst waiting in IDLE ages; anything else restarts it.
  assign to_window    = (state_q == ST_IDLE) & (cnt_q != '0) & (cnt_q < BURST_C);
  assign timeout_fire = to_window & (to_q == TW'(TIMEOUT - 1));

  // Age counter: a new word restarts the wait, as does any launch.
  always_comb begin
    to_d = '0;
    if (wr_accept || launch) begin
      to_d = '0;
    end else if (to_window) begin
      to_d = to_q + TW'(1);
    end
  end

  // Age counter register
  always_ff @(posedge ft_clk) begin
    if (ft_rst) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

  // FIFO pointer and occupancy update; a simultaneous write and transfer
  // leaves the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (xfer) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_accept, xfer})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Burst controller next state.  The strobe and busy flags are computed from
  // the next state so they come straight out of flops.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    pend_d   = pend_q | (flush & (cnt_q != '0));

    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d  = ST_ARM;
          remain_d = launch_len;
          // A launch that takes everything buffered satisfies the flush.
          if (CW'(launch_len) == cnt_q) begin
            pend_d = 1'b0;
          end
        end
      end
      ST_ARM: begin
        if (!FT_TXE_N) begin
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (xfer) begin
          remain_d = remain_q - RW'(1);
          if (remain_q == RW'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    wr_n_d = (state_d != ST_BURST);
    busy_d = (state_d != ST_IDLE);
  end

  // Control registers
  always_ff @(posedge ft_clk) begin
    if (ft_rst) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
      pend_q   <= 1'b0;
      wr_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      pend_q   <= pend_d;
      wr_n_q   <= wr_n_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage has no reset; emptiness is tracked by the pointers alone.
  always_ff @(posedge ft_clk) begin
    if (!ft_rst && wr_accept) begin
      mem_q[wr_ptr_q] <= {wr_be, wr_data};
    end
  end

  // Show-ahead head.  An empty FIFO presents zeros so the bus is quiet
  // (and at zero straight out of reset).
  assign head    = mem_q[rd_ptr_q];
  assign FT_DATA = (cnt_q != '0) ? head[DATA_W-1:0]  : '0;
  assign FT_BE   = (cnt_q != '0) ? head[WW-1:DATA_W] : '0;

  assign wr_dcnt   = cnt_q;
  assign busy      = busy_q;
  assign FT_WR_N   = wr_n_q;
  assign FT_RD_N   = 1'b1;
  assign FT_OE_N   = 1'b1;
  assign FT_SIWU_N = 1'b1;

endmodule

// File: tb/tb_ft601q_burst_tx.sv
// ---------------------------------------------------------------------------
// tb_ft601q_burst_tx
//
// Directed testbench for ft601q_burst_tx with DEPTH=1024, BURST=256 and
// TIMEOUT=16.  A negedge monitor captures every word the bus actually
// transfers and tallies strobe-low cycles, strobe runs and busy cycles; the
// stimulus keeps its own queue of words it expects to see on the bus.
// ---------------------------------------------------------------------------
module tb_ft601q_burst_tx;

   localparam int DATA_W  = 32;
   localparam int DEPTH   = 1024;
   localparam int BURST   = 256;
   localparam int TIMEOUT = 16;

   logic        ftClk;
   logic        ftRst;
   logic        wrEn;
   logic [31:0] wrData;
   logic [3:0]  wrBe;
   logic        wrFull;
   logic [10:0] wrDcnt;
   logic        flushIn;
   logic        busyOut;
   logic        txeN;
   logic        wrN;
   logic [3:0]  ftBe;
   logic [31:0] ftData;
   logic        rdN;
   logic        oeN;
   logic        siwuN;

   int checks;
   int errors;

   logic [35:0] expQ[$];
   logic [35:0] gotQ[$];
   int          lowCycles;
   int          lowRuns;
   int          busyCycles;
   logic        prevWrN;

   ft601q_burst_tx #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .BURST  (BURST),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .ft_clk   (ftClk),
      .ft_rst   (ftRst),
      .wr_en    (wrEn),
      .wr_data  (wrData),
      .wr_be    (wrBe),
      .wr_full  (wrFull),
      .wr_dcnt  (wrDcnt),
      .flush    (flushIn),
      .busy     (busyOut),
      .FT_TXE_N (txeN),
      .FT_WR_N  (wrN),
      .FT_BE    (ftBe),
      .FT_DATA  (ftData),
      .FT_RD_N  (rdN),
      .FT_OE_N  (oeN),
      .FT_SIWU_N(siwuN)
   );

   // 100 MHz bus clock
   initial ftClk = 1'b0;
   always #5 ftClk = ~ftClk;

   // Bus monitor: inputs change just after the rising edge, so values seen at
   // the falling edge are the ones the next rising edge acts on.
   always @(negedge ftClk) begin
      if (!wrN && !txeN) gotQ.push_back({ftBe, ftData});
      if (!wrN) begin
         lowCycles++;
         if (prevWrN) lowRuns++;
      end
      if (busyOut) busyCycles++;
      prevWrN = wrN;
   end

   // Hard stop in case something wedges the stimulus
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Counts one comparison and reports it when it does not hold
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of user/bus inputs and returns just after the edge
   task automatic applyStimulus(input logic en, input logic [31:0] data,
                                input logic [3:0] be, input logic fl,
                                input logic txe);
      wrEn    = en;
      wrData  = data;
      wrBe    = be;
      flushIn = fl;
      txeN    = txe;
      @(posedge ftClk);
      #1;
   endtask

   task automatic writeWords(input int n, input logic [31:0] base, input logic txe);
      logic [31:0] d;
      logic [3:0]  b;
      for (int i = 0; i < n; i++) begin
         d = base + 32'(i);
         b = 4'(i);
         expQ.push_back({b, d});
         applyStimulus(1'b1, d, b, 1'b0, txe);
      end
      wrEn = 1'b0;
   endtask

   task automatic clearMon();
      expQ.delete();
      gotQ.delete();
      lowCycles  = 0;
      lowRuns    = 0;
      busyCycles = 0;
   endtask

   // Runs with TXE low until the FIFO is empty and the controller idle.
   // With useFlush set, a flush is pulsed whenever words wait in IDLE.
   task automatic drainFifo(input string tag, input logic useFlush, input int maxCycles);
      logic done;
      logic fl;
      done = 1'b0;
      for (int i = 0; i < maxCycles; i++) begin
         if (wrDcnt == 0 && !busyOut) begin
            done = 1'b1;
            break;
         end
         fl = useFlush && (wrDcnt != 0) && !busyOut;
         applyStimulus(1'b0, 32'h0, 4'h0, fl, 1'b0);
      end
      if (!done) done = (wrDcnt == 0 && !busyOut);
      checkOutput({tag, "_drained"}, 64'(done), 64'd1);
   endtask

   task automatic compareQueues(input string tag);
      checkOutput({tag, "_count"}, 64'(gotQ.size()), 64'(expQ.size()));
      for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
         if (gotQ[i] !== expQ[i]) begin
            checkOutput($sformatf("%s_word%0d", tag, i), 64'(gotQ[i]), 64'(expQ[i]));
         end else begin
            checks++;
         end
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      prevWrN = 1'b1;
      ftRst   = 1'b1;
      wrEn    = 1'b0;
      wrData  = '0;
      wrBe    = '0;
      flushIn = 1'b0;
      txeN    = 1'b1;
      clearMon();

      // ---------------- reset state ----------------
      repeat (3) @(posedge ftClk);
      #1;
      checkOutput("rst_dcnt", 64'(wrDcnt), 64'd0);
      checkOutput("rst_full", 64'(wrFull), 64'd0);
      checkOutput("rst_busy", 64'(busyOut), 64'd0);
      checkOutput("rst_wrn", 64'(wrN), 64'd1);
      checkOutput("rst_be", 64'(ftBe), 64'd0);
      checkOutput("rst_data", 64'(ftData), 64'd0);
      checkOutput("tied_high", 64'({rdN, oeN, siwuN}), 64'h7);
      ftRst = 1'b0;
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);

      // ---------------- full burst ----------------
      $display("[TB] full 256-word burst");
      clearMon();
      writeWords(256, 32'hA000_0000, 1'b0);
      checkOutput("fb_dcnt", 64'(wrDcnt), 64'd256);
      checkOutput("fb_idle", 64'(busyOut), 64'd0);
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      checkOutput("fb_arm_busy", 64'(busyOut), 64'd1);
      checkOutput("fb_arm_wrn", 64'(wrN), 64'd1);
      drainFifo("fb", 1'b0, 600);
      checkOutput("fb_low_cycles", 64'(lowCycles), 64'd256);
      checkOutput("fb_runs", 64'(lowRuns), 64'd1);
      checkOutput("fb_dcnt_end", 64'(wrDcnt), 64'd0);
      compareQueues("fb");

      // ---------------- flush of a partial burst ----------------
      $display("[TB] flush of 10 words");
      clearMon();
      writeWords(10, 32'hB000_0000, 1'b0);
      checkOutput("fl_dcnt", 64'(wrDcnt), 64'd10);
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
      drainFifo("fl", 1'b0, 100);
      checkOutput("fl_low_cycles", 64'(lowCycles), 64'd10);
      checkOutput("fl_runs", 64'(lowRuns), 64'd1);
      compareQueues("fl");
      clearMon();
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
      repeat (20) applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      checkOutput("fl_empty_busy", 64'(busyCycles), 64'd0);
      checkOutput("fl_empty_low", 64'(lowCycles), 64'd0);

      // ---------------- stall mid-burst ----------------
      $display("[TB] TXE stall after word 100");
      clearMon();
      writeWords(256, 32'hC000_0000, 1'b1);
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
      checkOutput("st_arm_busy", 64'(busyOut), 64'd1);
      checkOutput("st_arm_wrn", 64'(wrN), 64'd1);
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      checkOutput("st_burst_wrn", 64'(wrN), 64'd0);
      checkOutput("st_head0", 64'(ftData), 64'hC000_0000);
      repeat (100) applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      checkOutput("st_dcnt100", 64'(wrDcnt), 64'd156);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
         checkOutput("st_hold_data", 64'(ftData), 64'hC000_0064);
         checkOutput("st_hold_wrn", 64'(wrN), 64'd0);
         checkOutput("st_hold_dcnt", 64'(wrDcnt), 64'd156);
      end
      expQ.push_back({4'hF, 32'hCAFE_0001});
      applyStimulus(1'b1, 32'hCAFE_0001, 4'hF, 1'b0, 1'b0);
      wrEn = 1'b0;
      checkOutput("st_wr_and_xfer_dcnt", 64'(wrDcnt), 64'd156);
      drainFifo("st", 1'b1, 800);
      checkOutput("st_low_cycles", 64'(lowCycles), 64'd262);
      checkOutput("st_runs", 64'(lowRuns), 64'd2);
      compareQueues("st");

      // ---------------- fill to full ----------------
      $display("[TB] fill FIFO to DEPTH");
      clearMon();
      writeWords(1024, 32'hD000_0000, 1'b1);
      checkOutput("ff_full", 64'(wrFull), 64'd1);
      checkOutput("ff_dcnt", 64'(wrDcnt), 64'd1024);
      applyStimulus(1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1);
      wrEn = 1'b0;
      checkOutput("ff_drop_dcnt", 64'(wrDcnt), 64'd1024);
      checkOutput("ff_drop_full", 64'(wrFull), 64'd1);
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      checkOutput("ff_enter_full", 64'(wrFull), 64'd1);
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      checkOutput("ff_after_xfer_full", 64'(wrFull), 64'd0);
      checkOutput("ff_after_xfer_dcnt", 64'(wrDcnt), 64'd1023);
      drainFifo("ff", 1'b0, 3000);
      compareQueues("ff");

      // ---------------- idle partial burst ----------------
      $display("[TB] partial burst left idle");
      clearMon();
      writeWords(3, 32'hE000_0000, 1'b0);
`ifdef FT601Q_TX_TIMEOUT_FLUSH_EN
      repeat (15) applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      checkOutput("to_before", 64'(busyOut), 64'd0);
      checkOutput("to_before_dcnt", 64'(wrDcnt), 64'd3);
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      checkOutput("to_launch", 64'(busyOut), 64'd1);
      drainFifo("to", 1'b0, 100);
`else
      repeat (40) applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      checkOutput("to_none_busy", 64'(busyCycles), 64'd0);
      checkOutput("to_none_dcnt", 64'(wrDcnt), 64'd3);
      drainFifo("to", 1'b1, 100);
`endif
      compareQueues("to");

      // ---------------- reset mid-burst ----------------
      $display("[TB] reset during word 50");
      clearMon();
      writeWords(256, 32'hF000_0000, 1'b1);
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      repeat (50) applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      checkOutput("rb_head50", 64'(ftData), 64'hF000_0032);
      checkOutput("rb_wrn_before", 64'(wrN), 64'd0);
      ftRst = 1'b1;
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      checkOutput("rb_wrn", 64'(wrN), 64'd1);
      checkOutput("rb_dcnt", 64'(wrDcnt), 64'd0);
      checkOutput("rb_busy", 64'(busyOut), 64'd0);
      checkOutput("rb_full", 64'(wrFull), 64'd0);
      checkOutput("rb_data", 64'(ftData), 64'd0);
      ftRst = 1'b0;
      busyCycles = 0;
      repeat (10) applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      checkOutput("rb_after_busy", 64'(busyCycles), 64'd0);
      checkOutput("rb_after_dcnt", 64'(wrDcnt), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
